urv_ahb_sram_slave: RTL and testbench
=====================================

// Module: urv_ahb_sram_slave
// PURPOSE
//  AHB-Lite responder: single-port word-organised SRAM on the core's data bus.
//  Receives the loads and stores the execute stage issues: HTRANS NONSEQ, HSIZE byte/half/word.
//  Supports configurable wait states and a standard two-cycle ERROR response for misaligned accesses.
//  Sits behind the bus decoder; drives HREADYOUT, HRDATA and HRESP back to the master.
// PARAMETERS
//  ADDR_WIDTH   10  word-address bits; memory depth = 2**ADDR_WIDTH words; HADDR[ADDR_WIDTH+1:2] indexes it
//  WAIT_STATES  0   extra data-phase cycles with HREADYOUT=0 per OKAY transfer, 0..15
// PORTS
//  clk_i      in   1   clock, rising edge
//  rst_i      in   1   asynchronous active-low reset
//  HSEL       in   1   slave select from decoder
//  HADDR      in   32  address-phase address
//  HTRANS     in   2   transfer type (only bit 1 significant: NONSEQ/SEQ = active)
//  HWRITE     in   1   1 = write
//  HSIZE      in   3   0 = byte, 1 = half, 2 = word; >2 is an error
//  HWDATA     in   32  write data (data phase)
//  HREADY     in   1   bus-level ready (address phase qualifier)
//  HREADYOUT  out  1   slave ready
//  HRESP      out  1   0 = OKAY, 1 = ERROR
//  HRDATA     out  32  read data, valid while HREADYOUT=1 in a read data phase
// BEHAVIOUR
//  - Reset: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, pending write cleared; memory contents not reset.
//  - Accept: HSEL && HREADY && HTRANS[1] on a rising edge; latch addr, size, write, misalign flag.
//  - Misaligned: (HSIZE==1 && HADDR[0]) || (HSIZE==2 && HADDR[1:0]!=0) || HSIZE>2.
//  - Not accepted (IDLE/BUSY/HSEL=0): the next cycle gives HREADYOUT=1, HRESP=0, with no memory effect.
//  - HADDR bits above ADDR_WIDTH+1 are ignored (memory aliases).
//  - FSM states: IDLE, DATA, WAIT, ERR1, ERR2.
//      IDLE/DATA --accept, misaligned--> ERR1
//      IDLE/DATA --accept, aligned, WAIT_STATES>0--> WAIT; counter loads WAIT_STATES
//      IDLE/DATA --accept, aligned, WAIT_STATES==0--> DATA
//      IDLE/DATA --no accept--> IDLE
//      WAIT: HREADYOUT=0, counter decrements each cycle; at 1 --> DATA
//      DATA: HREADYOUT=1, HRESP=0; write commits this cycle; new accept is legal (pipelined)
//      ERR1: HREADYOUT=0, HRESP=1 --> ERR2
//      ERR2: HREADYOUT=1, HRESP=1 --> IDLE, or follows accept rules if a new transfer is accepted
//  - Errored transfers never modify memory; their HRDATA is don't-care (drive 0).
//  - Write: byte lanes from latched size/addr[1:0]
//      byte: lane = addr[1:0]; half: lanes {addr[1],0}+1:0; word: all 4
//      memory is written with HWDATA lanes on the clock edge that ends the DATA cycle (HREADYOUT=1)
//  - Read: memory word is read synchronously when the read completes into DATA, so HRDATA is a
//    registered value in DATA. With zero wait states, that read happens on the accept edge.
//    Full 32-bit word is returned regardless of HSIZE; the master selects the lanes.
//    HRDATA holds its value until the next read completes.
//  - Read-after-write hazard: a read accepted in the same cycle as a write's DATA phase to the same word
//    returns the merged word: written lanes from HWDATA, other lanes from memory (bypass).
//    A different word gets no bypass.
//  - Back-to-back NONSEQ: one transfer per cycle with WAIT_STATES=0.
//  - Reset mid-transfer: aborts immediately; a write still in its DATA phase is discarded.
// TESTING
//  1. Word write 0xDEADBEEF @0x10, then word read @0x10, WAIT_STATES=0
//     -> HRDATA=0xDEADBEEF in the 2nd data phase, HREADYOUT=1 throughout, HRESP=0.
//  2. Word @0x20 = 0x11223344; byte write 0xAA @0x21, half write 0x5566 @0x22; read @0x20
//     -> HRDATA=0x5566AA44.
//  3. Write 0xCAFEF00D @0x30 immediately followed by read @0x30 (pipelined)
//     -> bypass returns 0xCAFEF00D; read @0x34 in the same slot -> old @0x34 contents.
//  4. Word write @0x42 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1);
//     word @0x40 unchanged; repeat with HSIZE=3 -> same error response.
//  5. WAIT_STATES=3, read @0x10 -> HREADYOUT low for exactly 3 cycles, then 1 with data.
//     HTRANS=IDLE with HSEL=1 -> zero-wait OKAY, no write.
//  6. Assert rst_i=0 during WAIT of a write -> HREADYOUT=1, HRESP=0, HRDATA=0 at once;
//     after release the target word is unchanged.

Source files
------------

// File: rtl/urv_ahb_sram_slave_if.sv
// AHB-Lite bus bundle between one master (or interconnect) and the SRAM responder.
// Signals: HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA/HREADY travel toward the slave;
//          HREADYOUT/HRESP/HRDATA travel back toward the master.
interface urv_ahb_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/urv_ahb_sram_slave.sv
// AHB-Lite responder in front of a single-port word-organised SRAM (byte/half/word accesses).
// Latency: data phase follows the accepting edge, plus WAIT_STATES cycles; misaligned -> 2-cycle ERROR.
// Backpressure: HREADYOUT low during wait states and ERR1; one transfer per cycle with no wait states.
// Ports: clk_i, rst_i (async active-low), bus (slave modport of urv_ahb_sram_slave_if).
module urv_ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    urv_ahb_sram_slave_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, DATA, WAIT, ERR1, ERR2} state_t;

    state_t                  state, state_nx;
    logic [3:0]              cnt;
    logic [ADDR_WIDTH+1:0]   addr_q;
    logic [2:0]              size_q;
    logic                    write_q;
    logic [31:0]             rdata_q;

    logic [31:0] mem [2**ADDR_WIDTH];

    logic                    accept, can_accept, take, misaligned;
    logic                    commit_we;
    logic [3:0]              wr_mask;
    logic [ADDR_WIDTH-1:0]   wr_idx, rd_idx;
    logic [31:0]             rd_word;

    // Upper address bits alias the array; HTRANS[0] (SEQ vs NONSEQ) carries no meaning here.
    logic unused_ok;
    assign unused_ok = ^{bus.HADDR[31:ADDR_WIDTH+2], bus.HTRANS[0]};

    function automatic logic [3:0] lane_mask(input logic [2:0] sz, input logic [1:0] a);
        case (sz)
            3'd0:    lane_mask = 4'b0001 << a;
            3'd1:    lane_mask = a[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    assign accept     = bus.HSEL && bus.HREADY && bus.HTRANS[1];
    assign misaligned = (bus.HSIZE == 3'd1 && bus.HADDR[0]) ||
                        (bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'b00) ||
                        (bus.HSIZE > 3'd2);
    // Only states that end with HREADYOUT=1 can start a new transfer.
    assign can_accept = (state == IDLE) || (state == DATA) || (state == ERR2);
    assign take       = accept && can_accept;

    assign wr_idx    = addr_q[ADDR_WIDTH+1:2];
    assign rd_idx    = bus.HADDR[ADDR_WIDTH+1:2];
    assign wr_mask   = lane_mask(size_q, addr_q[1:0]);
    assign commit_we = (state == DATA) && write_q;

    // Zero-wait read of the word a write is committing this same cycle sees the new lanes.
    always_comb begin
        rd_word = mem[rd_idx];
        if (commit_we && wr_idx == rd_idx) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) rd_word[8*i +: 8] = bus.HWDATA[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DATA, ERR2: begin
                if (take) begin
                    if (misaligned)           state_nx = ERR1;
                    else if (WAIT_STATES > 0) state_nx = WAIT;
                    else                      state_nx = DATA;
                end else begin
                    state_nx = IDLE;
                end
            end
            WAIT:    state_nx = (cnt == 4'd1) ? DATA : WAIT;
            ERR1:    state_nx = ERR2;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= '0;
            size_q  <= 3'd0;
            write_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state <= state_nx;
            if (take) begin
                addr_q  <= bus.HADDR[ADDR_WIDTH+1:0];
                size_q  <= bus.HSIZE;
                write_q <= bus.HWRITE && !misaligned;
                cnt     <= 4'(WAIT_STATES);
                if (!bus.HWRITE && !misaligned && WAIT_STATES == 0) rdata_q <= rd_word;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1 && !write_q) rdata_q <= mem[wr_idx];
            end else if (state == DATA) begin
                write_q <= 1'b0;
            end
        end
    end

    // Reset forces state to IDLE asynchronously, so an in-flight write never commits.
    always_ff @(posedge clk_i) begin
        if (commit_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) mem[wr_idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
            end
        end
    end

    assign bus.HREADYOUT = !((state == WAIT) || (state == ERR1));
    assign bus.HRESP     = (state == ERR1) || (state == ERR2);
    assign bus.HRDATA    = bus.HRESP ? 32'd0 : rdata_q;
endmodule

// File: tb/tb_urv_ahb_sram_slave.sv
module tb_urv_ahb_sram_slave;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   lows;

    urv_ahb_sram_slave_if if0();
    urv_ahb_sram_slave_if if3();

    // Single slave on each bus: bus-level HREADY is the slave's own HREADYOUT.
    assign if0.HREADY = if0.HREADYOUT;
    assign if3.HREADY = if3.HREADYOUT;

    urv_ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (if0.slave)
    );

    urv_ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(3)) dut3 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (if3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ap0(input logic act, input logic wr, input logic [2:0] sz, input logic [31:0] ad);
        if0.HSEL   = 1'b1;
        if0.HTRANS = act ? 2'b10 : 2'b00;
        if0.HWRITE = wr;
        if0.HSIZE  = sz;
        if0.HADDR  = ad;
    endtask

    task automatic ap3(input logic act, input logic wr, input logic [2:0] sz, input logic [31:0] ad);
        if3.HSEL   = 1'b1;
        if3.HTRANS = act ? 2'b10 : 2'b00;
        if3.HWRITE = wr;
        if3.HSIZE  = sz;
        if3.HADDR  = ad;
    endtask

    // Counts data-phase cycles with HREADYOUT low on the wait-state slave, bounded.
    task automatic count_lows3(output int n);
        n = 0;
        while (if3.HREADYOUT !== 1'b1 && n < 50) begin
            n++;
            tick();
        end
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        ap0(1'b0, 1'b0, 3'd2, 32'h0);
        ap3(1'b0, 1'b0, 3'd2, 32'h0);
        if0.HWDATA = 32'h0;
        if3.HWDATA = 32'h0;
        #2;
        check("rst_rdy0",   if0.HREADYOUT, 1);
        check("rst_resp0",  if0.HRESP,     0);
        check("rst_rdata0", if0.HRDATA,    0);
        check("rst_rdy3",   if3.HREADYOUT, 1);
        #10 rst_n = 1'b1;
        tick();

        // 1: word write then word read, zero wait states
        ap0(1'b1, 1'b1, 3'd2, 32'h10); tick();
        if0.HWDATA = 32'hDEADBEEF; ap0(1'b1, 1'b0, 3'd2, 32'h10);
        check("t1_wr_rdy",  if0.HREADYOUT, 1);
        check("t1_wr_resp", if0.HRESP,     0);
        tick();
        ap0(1'b0, 1'b0, 3'd2, 32'h0);
        check("t1_rd_rdy",  if0.HREADYOUT, 1);
        check("t1_rd_resp", if0.HRESP,     0);
        check("t1_rdata",   if0.HRDATA,    32'hDEADBEEF);
        tick();

        // 2: word, byte, half writes then read (last write bypassed into the read)
        ap0(1'b1, 1'b1, 3'd2, 32'h20); tick();
        if0.HWDATA = 32'h11223344; ap0(1'b1, 1'b1, 3'd0, 32'h21); tick();
        if0.HWDATA = 32'h0000AA00; ap0(1'b1, 1'b1, 3'd1, 32'h22); tick();
        if0.HWDATA = 32'h55660000; ap0(1'b1, 1'b0, 3'd2, 32'h20); tick();
        ap0(1'b0, 1'b0, 3'd2, 32'h0);
        check("t2_merge", if0.HRDATA, 32'h5566AA44);
        tick();
        ap0(1'b1, 1'b0, 3'd2, 32'h20); tick();
        ap0(1'b0, 1'b0, 3'd2, 32'h0);
        check("t2_mem", if0.HRDATA, 32'h5566AA44);
        tick();

        // 3: pipelined read-after-write, same word and different word
        ap0(1'b1, 1'b1, 3'd2, 32'h34); tick();
        if0.HWDATA = 32'h12345678; ap0(1'b0, 1'b0, 3'd2, 32'h0); tick();
        ap0(1'b1, 1'b1, 3'd2, 32'h30); tick();
        if0.HWDATA = 32'hCAFEF00D; ap0(1'b1, 1'b0, 3'd2, 32'h30); tick();
        ap0(1'b0, 1'b0, 3'd2, 32'h0);
        check("t3_bypass", if0.HRDATA, 32'hCAFEF00D);
        tick();
        ap0(1'b1, 1'b1, 3'd2, 32'h30); tick();
        if0.HWDATA = 32'h0BADCAFE; ap0(1'b1, 1'b0, 3'd2, 32'h34); tick();
        ap0(1'b0, 1'b0, 3'd2, 32'h0);
        check("t3_nobypass", if0.HRDATA, 32'h12345678);
        tick();
        ap0(1'b1, 1'b0, 3'd2, 32'h30); tick();
        ap0(1'b0, 1'b0, 3'd2, 32'h0);
        check("t3_mem30", if0.HRDATA, 32'h0BADCAFE);
        tick();

        // 4: misaligned word write and HSIZE=3 give two-cycle ERROR, no memory effect
        ap0(1'b1, 1'b1, 3'd2, 32'h40); tick();
        if0.HWDATA = 32'h40404040; ap0(1'b0, 1'b0, 3'd2, 32'h0); tick();
        ap0(1'b1, 1'b1, 3'd2, 32'h42); tick();
        if0.HWDATA = 32'hFFFFFFFF; ap0(1'b0, 1'b0, 3'd2, 32'h0);
        check("t4_err1_rdy",  if0.HREADYOUT, 0);
        check("t4_err1_resp", if0.HRESP,     1);
        tick();
        check("t4_err2_rdy",  if0.HREADYOUT, 1);
        check("t4_err2_resp", if0.HRESP,     1);
        check("t4_err2_data", if0.HRDATA,    0);
        tick();
        check("t4_idle_resp", if0.HRESP, 0);
        ap0(1'b1, 1'b1, 3'd3, 32'h40); tick();
        ap0(1'b0, 1'b0, 3'd2, 32'h0);
        check("t4_sz3_err1_rdy",  if0.HREADYOUT, 0);
        check("t4_sz3_err1_resp", if0.HRESP,     1);
        tick();
        check("t4_sz3_err2_rdy",  if0.HREADYOUT, 1);
        check("t4_sz3_err2_resp", if0.HRESP,     1);
        tick();
        ap0(1'b1, 1'b0, 3'd2, 32'h40); tick();
        ap0(1'b0, 1'b0, 3'd2, 32'h0);
        check("t4_mem40", if0.HRDATA, 32'h40404040);
        tick();

        // 5: three wait states on write and read; IDLE transfer is a no-op
        ap3(1'b1, 1'b1, 3'd2, 32'h10); tick();
        if3.HWDATA = 32'h5A5AA5A5; ap3(1'b0, 1'b0, 3'd2, 32'h0);
        count_lows3(lows);
        check("t5_wr_waits", 32'(lows), 3);
        check("t5_wr_resp",  if3.HRESP, 0);
        tick();
        ap3(1'b1, 1'b0, 3'd2, 32'h10); tick();
        ap3(1'b0, 1'b0, 3'd2, 32'h0);
        count_lows3(lows);
        check("t5_rd_waits", 32'(lows), 3);
        check("t5_rd_rdy",   if3.HREADYOUT, 1);
        check("t5_rdata",    if3.HRDATA,    32'h5A5AA5A5);
        tick();
        ap3(1'b0, 1'b1, 3'd2, 32'h10); if3.HWDATA = 32'h0; tick();
        ap3(1'b0, 1'b0, 3'd2, 32'h0);
        check("t5_idle_rdy",  if3.HREADYOUT, 1);
        check("t5_idle_resp", if3.HRESP,     0);
        tick();
        ap3(1'b1, 1'b0, 3'd2, 32'h10); tick();
        ap3(1'b0, 1'b0, 3'd2, 32'h0);
        count_lows3(lows);
        check("t5_idle_nowrite", if3.HRDATA, 32'h5A5AA5A5);
        tick();

        // 6: reset during the wait states of a write discards it
        ap3(1'b1, 1'b1, 3'd2, 32'h10); tick();
        if3.HWDATA = 32'h77777777; ap3(1'b0, 1'b0, 3'd2, 32'h0); tick();
        check("t6_in_wait", if3.HREADYOUT, 0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_rdy",   if3.HREADYOUT, 1);
        check("t6_rst_resp",  if3.HRESP,     0);
        check("t6_rst_rdata", if3.HRDATA,    0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        ap3(1'b1, 1'b0, 3'd2, 32'h10); tick();
        ap3(1'b0, 1'b0, 3'd2, 32'h0);
        count_lows3(lows);
        check("t6_waits",     32'(lows), 3);
        check("t6_unchanged", if3.HRDATA, 32'h5A5AA5A5);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
